demux_stream_nch: RTL and testbench



---
 rtl/demux_stream_nch.sv | 123 ++++++++++++
 tb/tb_demux_stream_nch.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_nch.sv
`timescale 1ns/1ps
// demux_stream_nch
// Registered 1-to-NUM_OUT stream demultiplexer. Each output channel has a
// one-entry holding register with its own valid/ready handshake. A beat whose
// select is out of range is dropped and raises the sticky err_sel flag.
// Optional feature: define DEMUX_BCAST_EN to add the bcast input, which copies
// one beat into every channel at once.
module demux_stream_nch #(
    parameter int               BITS    = 8,
    parameter int               NUM_OUT = 4,
    parameter logic [BITS-1:0]  DEFAULT = '0,
    localparam int              SEL_BITS = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef DEMUX_BCAST_EN
    input  logic                      bcast,
`endif
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_BITS-1:0]       in_sel,
    input  logic [BITS-1:0]           in_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*BITS-1:0]   out_data,
    output logic                      err_sel,
    input  logic                      err_clr
);

    // One extra bit so the range test also works when NUM_OUT is a power of 2.
    localparam logic [SEL_BITS:0] NUM_OUT_W = (SEL_BITS + 1)'(NUM_OUT);

    logic [NUM_OUT-1:0]      r_valid;
    logic [NUM_OUT*BITS-1:0] r_data;
    logic                    r_err;

    logic [NUM_OUT-1:0]      w_can_load;
    logic [NUM_OUT-1:0]      w_sel_onehot;
    logic [NUM_OUT-1:0]      w_load;
    logic                    w_sel_in_range;
    logic                    w_accept;
    logic                    w_bad_accept;

    // A channel can take a beat when empty or when its current beat drains now.
    assign w_can_load     = ~r_valid | out_ready;
    assign w_sel_in_range = {1'b0, in_sel} < NUM_OUT_W;

    // Decode the select into a one-hot channel mask (all zero when out of range).
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        w_sel_onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (in_sel == SEL_BITS'(i)) begin
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    // Handshake and per-channel load enables; in_ready never looks at in_valid.
    always_comb begin
        in_ready     = 1'b1;
        w_accept     = 1'b0;
        w_load       = '0;
        w_bad_accept = 1'b0;
`ifdef DEMUX_BCAST_EN
        if (bcast) begin
            // Broadcast waits until every channel can take the beat together.
            in_ready = &w_can_load;
            w_accept = in_valid && in_ready;
            w_load   = {NUM_OUT{w_accept}};
        end else begin
            in_ready     = w_sel_in_range ? |(w_sel_onehot & w_can_load) : 1'b1;
            w_accept     = in_valid && in_ready;
            w_load       = w_accept ? w_sel_onehot : '0;
            w_bad_accept = w_accept && !w_sel_in_range;
        end
`else
        in_ready     = w_sel_in_range ? |(w_sel_onehot & w_can_load) : 1'b1;
        w_accept     = in_valid && in_ready;
        w_load       = w_accept ? w_sel_onehot : '0;
        w_bad_accept = w_accept && !w_sel_in_range;
`endif
    end

    // Holding registers: load wins over drain, so a channel streams without bubbles.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data registers are reset too, because an idle channel must
        // drive DEFAULT on its data from the very first cycle after reset.
        if (rst) begin
            r_valid <= '0;
            r_data  <= {NUM_OUT{DEFAULT}};
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            for (int i = 0; i < NUM_OUT; i++) begin
                if (w_load[i]) begin
                    r_valid[i]               <= 1'b1;
                    r_data[i*BITS +: BITS]   <= in_data;
                end else if (r_valid[i] && out_ready[i]) begin
                    r_valid[i]               <= 1'b0;
                    r_data[i*BITS +: BITS]   <= DEFAULT;
                end
            end
        end
    end

    // Sticky select-error flag; a new bad beat beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_bad_accept) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign err_sel   = r_err;

endmodule

// File: tb/tb_demux_stream_nch.sv
`timescale 1ns/1ps
// tb_demux_stream_nch
// Directed bench with a scoreboard. The driver pushes {channel, data} for
// every accepted beat; a negedge monitor pops and compares each completed
// output transfer. A second instance with NUM_OUT=3 covers the select error.
module tb_demux_stream_nch;

    localparam logic [7:0] DEF = 8'hEE;

    typedef struct packed {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_sel;
    logic [7:0]  in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic        err_sel;
    logic        err_clr;
`ifdef DEMUX_BCAST_EN
    logic        bcast;
`endif

    logic        in3_valid;
    logic        in3_ready;
    logic [1:0]  in3_sel;
    logic [7:0]  in3_data;
    logic [2:0]  out3_valid;
    logic [2:0]  out3_ready;
    logic [23:0] out3_data;
    logic        err3_sel;
    logic        err3_clr;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    int   vcnt[4];
    logic [7:0] prev_d[4];
    logic       prev_hold[4];

    always #5 clk = ~clk;

    demux_stream_nch #(.BITS(8), .NUM_OUT(4), .DEFAULT(DEF)) u_dut (
        .clk       (clk),
        .rst       (rst),
`ifdef DEMUX_BCAST_EN
        .bcast     (bcast),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_sel   (err_sel),
        .err_clr   (err_clr)
    );

    demux_stream_nch #(.BITS(8), .NUM_OUT(3), .DEFAULT(8'h00)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
`ifdef DEMUX_BCAST_EN
        .bcast     (1'b0),
`endif
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .in_sel    (in3_sel),
        .in_data   (in3_data),
        .out_valid (out3_valid),
        .out_ready (out3_ready),
        .out_data  (out3_data),
        .err_sel   (err3_sel),
        .err_clr   (err3_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted; records the expectation.
    task automatic send(input logic [1:0] sel, input logic [7:0] data, inout int stalls);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stalls++;
            waited++;
            if (waited > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: ch%0d beat %h never accepted", sel, data);
                break;
            end
        end
        if (in_ready) exp_q.push_back('{chan: sel, data: data});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare completed transfers, output stability and idle data.
    always @(negedge clk) begin
        logic [7:0] d;
        int idx;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                d = out_data[i*8 +: 8];
                if (out_valid[i]) vcnt[i]++;
                if (out_valid[i] && prev_hold[i])
                    check($sformatf("ch%0d_stable", i), d, prev_d[i]);
                if (!out_valid[i])
                    check($sformatf("ch%0d_idle_data", i), d, DEF);
                if (out_valid[i] && out_ready[i]) begin
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++) begin
                        if (exp_q[j].chan == 2'(i)) begin
                            idx = j;
                            break;
                        end
                    end
                    if (idx < 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ch%0d_unexpected: got %h, expected no beat", i, d);
                    end else begin
                        check($sformatf("ch%0d_data", i), d, exp_q[idx].data);
                        exp_q.delete(idx);
                    end
                end
                prev_hold[i] <= out_valid[i] && !out_ready[i];
                prev_d[i]    <= d;
            end
        end else begin
            for (int i = 0; i < 4; i++) prev_hold[i] <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = 4'hF;
        err_clr   = 1'b0;
`ifdef DEMUX_BCAST_EN
        bcast     = 1'b0;
`endif
        in3_valid  = 1'b0;
        in3_sel    = '0;
        in3_data   = '0;
        out3_ready = 3'b111;
        err3_clr   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vcnt[i] = 0;
            prev_hold[i] = 1'b0;
            prev_d[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 4'h0);
        check("rst_out_data", out_data, {4{DEF}});
        check("rst_err_sel", err_sel, 1'b0);
        check("rst3_err_sel", err3_sel, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);

        // Routing: one beat per channel back-to-back, all ready
        @(posedge clk);
        #1;
        stalls = 0;
        for (int i = 0; i < 4; i++) vcnt[i] = 0;
        for (int k = 0; k < 4; k++) send(2'(k), 8'h10 + 8'(k), stalls);
        check("route_stalls", stalls, 0);
        @(negedge clk);
        check("route_last_valid", out_valid, 4'b1000);
        check("route_last_data", out_data[31:24], 8'h13);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("route_pulse_ch%0d", i), vcnt[i], 1);

        // Backpressure isolation on channel 1
        @(posedge clk);
        #1;
        out_ready = 4'b1101;
        stalls = 0;
        send(2'd1, 8'h55, stalls);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 8'h66;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 1'b0);
            check("bp_ch1_hold", {out_valid[1], out_data[15:8]}, {1'b1, 8'h55});
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
        @(negedge clk);
        check("bp_in_ready_release", in_ready, 1'b1);
        exp_q.push_back('{chan: 2'd1, data: 8'h66});
        @(posedge clk);
        #1;
        in_sel  = 2'd3;
        in_data = 8'h77;
        @(negedge clk);
        check("bp_ch1_no_gap", {out_valid[1], out_data[15:8]}, {1'b1, 8'h66});
        check("bp_ch3_ready", in_ready, 1'b1);
        exp_q.push_back('{chan: 2'd3, data: 8'h77});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_ch3_data", {out_valid[3], out_data[31:24]}, {1'b1, 8'h77});

        // Throughput: 16 beats to channel 2
        @(posedge clk);
        #1;
        stalls  = 0;
        vcnt[2] = 0;
        for (int k = 0; k < 16; k++) send(2'd2, 8'h80 + 8'(k), stalls);
        check("tput_stalls", stalls, 0);
        repeat (2) @(negedge clk);
        check("tput_valid_cycles", vcnt[2], 16);

`ifdef DEMUX_BCAST_EN
        // Broadcast with channel 2 full and stalled
        @(posedge clk);
        #1;
        out_ready = 4'b1011;
        stalls = 0;
        send(2'd2, 8'h22, stalls);
        bcast    = 1'b1;
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'hC3;
        repeat (2) begin
            @(negedge clk);
            check("bcast_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 4'hF;
        @(negedge clk);
        check("bcast_in_ready_high", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) exp_q.push_back('{chan: 2'(i), data: 8'hC3});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcast    = 1'b0;
        @(negedge clk);
        check("bcast_all_valid", out_valid, 4'hF);
        check("bcast_all_data", out_data, {4{8'hC3}});
        check("bcast_no_err", err_sel, 1'b0);
`endif

        // Reset mid-stream with channel 2 holding A5
        @(posedge clk);
        #1;
        out_ready = 4'b1011;
        stalls = 0;
        send(2'd2, 8'hA5, stalls);
        @(negedge clk);
        check("pre_rst_ch2", {out_valid[2], out_data[23:16]}, {1'b1, 8'hA5});
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 4'h0);
        check("async_rst_data", out_data, {4{DEF}});
        check("async_rst_err", err_sel, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 4'hF;
        send(2'd0, 8'h3C, stalls);
        @(negedge clk);
        check("post_rst_latency", out_valid, 4'b0001);

        // Select error on the NUM_OUT=3 instance
        @(posedge clk);
        #1;
        in3_valid = 1'b1;
        in3_sel   = 2'd3;
        in3_data  = 8'h99;
        @(negedge clk);
        check("err_in_ready", in3_ready, 1'b1);
        @(posedge clk);
        #1;
        in3_valid = 1'b0;
        check("err_no_out", out3_valid, 3'b000);
        check("err_set", err3_sel, 1'b1);
        err3_clr = 1'b1;
        @(posedge clk);
        #1;
        err3_clr = 1'b0;
        check("err_clr", err3_sel, 1'b0);
        in3_valid = 1'b1;
        @(posedge clk);
        #1;
        check("err_set_again", err3_sel, 1'b1);
        err3_clr = 1'b1;
        @(posedge clk);
        #1;
        check("err_set_wins", err3_sel, 1'b1);
        in3_valid = 1'b0;
        @(posedge clk);
        #1;
        err3_clr = 1'b0;
        check("err_clr_again", err3_sel, 1'b0);
        in3_valid = 1'b1;
        in3_sel   = 2'd2;
        in3_data  = 8'h5A;
        @(posedge clk);
        #1;
        in3_valid = 1'b0;
        check("n3_route", {out3_valid, out3_data[23:16]}, {3'b100, 8'h5A});
        check("n3_no_err", err3_sel, 1'b0);

        // Drain and final state
        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("main_err_never", err_sel, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
